bcd2bin_serial: RTL and testbench

BCD2BIN_SERIAL -- requirements
Module: bcd2bin_serial

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_mac10.sv | 16 +
 rtl/bcd2bin_serial.sv | 80 ++++++++
 tb/tb_bcd2bin_serial.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD-to-binary converter.
// The FSM state type and the decimal constants live here.
package bcd_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ACCUM = 1'b0;
    localparam state_t DONE  = 1'b1;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         RADIX   = 10;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add stage for the BCD accumulator.
// The result wraps modulo 2^OUT_W; there is no saturation.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int OUT_W = 7
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [OUT_W-1:0] result
);

    // acc*10 built from two shifts so no multiplier is inferred
    assign result = (acc << 3) + (acc << 1) + OUT_W'(digit);

endmodule

// File: rtl/bcd2bin_serial.sv
// Serial BCD-to-binary converter: NDIG digits in (MSD first), one binary result out.
// Define BCD2BIN_ERR_CHK_EN to flag digits above 9 on the err output.
module bcd2bin_serial
    import bcd_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             err
);

    localparam int                CNT_W = $clog2(NDIG + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NDIG - 1);

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             consume;

    assign din_ready  = (state == ACCUM);
    assign dout_valid = (state == DONE);
    assign accept     = din_valid & din_ready;
    assign consume    = dout_valid & dout_ready;
    assign dout       = acc;

    bcd_mac10 #(.OUT_W(OUT_W)) u_mac (
        .acc    (acc),
        .digit  (din),
        .result (acc_next)
    );

    // The accumulator doubles as the output register while in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
        end else if (consume) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                state <= DONE;
            end
        end
    end

`ifdef BCD2BIN_ERR_CHK_EN
    logic err_q;

    // Sticky until the result carrying the bad digit is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (consume) begin
            err_q <= 1'b0;
        end else if (accept && (din > BCD_MAX)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_serial.sv
// Self-checking bench for bcd2bin_serial: default 2-digit build plus two 4-digit builds.
// Expected results come from the full decimal value reduced modulo 2^OUT_W.
module tb_bcd2bin_serial;

`ifdef BCD2BIN_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [6:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       err;

    logic [3:0]  w_din;
    logic        w_din_valid;
    logic        w_dout_ready;
    logic        w14_din_ready, w7_din_ready;
    logic [13:0] w14_dout;
    logic [6:0]  w7_dout;
    logic        w14_dout_valid, w7_dout_valid;
    logic        w14_err, w7_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd2bin_serial #(.NDIG(2), .OUT_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err        (err)
    );

    bcd2bin_serial #(.NDIG(4), .OUT_W(14)) dut_w14 (
        .clk        (clk),
        .rst        (rst),
        .din        (w_din),
        .din_valid  (w_din_valid),
        .din_ready  (w14_din_ready),
        .dout       (w14_dout),
        .dout_valid (w14_dout_valid),
        .dout_ready (w_dout_ready),
        .err        (w14_err)
    );

    bcd2bin_serial #(.NDIG(4), .OUT_W(7)) dut_w7 (
        .clk        (clk),
        .rst        (rst),
        .din        (w_din),
        .din_valid  (w_din_valid),
        .din_ready  (w7_din_ready),
        .dout       (w7_dout),
        .dout_valid (w7_dout_valid),
        .dout_ready (w_dout_ready),
        .err        (w7_err)
    );

    // Reference: the decimal value of the digit string, wrapped to the output width
    function automatic longint model_value(input int digs[4], input int n, input int width);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 10 + digs[i];
        return v % (longint'(1) << width);
    endfunction

    function automatic bit model_err(input int digs[4], input int n);
        bit e = 1'b0;
        for (int i = 0; i < n; i++) if (digs[i] > 9) e = 1'b1;
        return ERR_EN & e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_main(input logic [3:0] d0, input logic [3:0] d1);
        din = d0;
        din_valid = 1'b1;
        tick();
        din = d1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_wide(input int digs[4]);
        w_din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_din = 4'(digs[i]);
            tick();
        end
        w_din_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        din = 4'd5;
        din_valid = 1'b1;
        dout_ready = 1'b0;
        w_din = 4'd3;
        w_din_valid = 1'b1;
        w_dout_ready = 1'b0;
        repeat (3) tick();
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_din_ready: got %b expected 1", din_ready);
        end
        vectors++;
        if (dout_valid !== 1'b0 || dout !== 7'd0 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got valid=%b dout=%0d err=%b expected 0/0/0", dout_valid, dout, err);
        end
        vectors++;
        if (w14_dout_valid !== 1'b0 || w14_dout !== 14'd0 || w7_din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_wide: got valid=%b dout=%0d ready=%b expected 0/0/1", w14_dout_valid, w14_dout, w7_din_ready);
        end
        rst = 1'b0;
        din_valid = 1'b0;
        w_din_valid = 1'b0;
    endtask

    task automatic test_basic;
        dout_ready = 1'b1;
        send_main(4'd1, 4'd5);
        vectors++;
        if (dout_valid !== 1'b1 || dout !== 7'h0F || err !== 1'b0 || din_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_result: got valid=%b dout=%0d err=%b ready=%b expected 1/15/0/0", dout_valid, dout, err, din_ready);
        end
        tick();
        vectors++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_one_cycle: got valid=%b ready=%b expected 0/1", dout_valid, din_ready);
        end
        tick();
        vectors++;
        if (dout_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_no_repeat: got valid=%b expected 0", dout_valid);
        end
    endtask

    task automatic test_sweep;
        dout_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            send_main(4'(v / 10), 4'(v % 10));
            vectors++;
            if (dout_valid !== 1'b1 || dout !== 7'(v)) begin
                miscompares++;
                $display("[TB] FAIL sweep_%0d: got valid=%b dout=%0d expected 1/%0d", v, dout_valid, dout, v);
            end
            tick();
        end
    endtask

    task automatic test_stall;
        dout_ready = 1'b0;
        send_main(4'd9, 4'd9);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (dout_valid !== 1'b1 || dout !== 7'd99 || din_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_%0d: got valid=%b dout=%0d ready=%b expected 1/99/0", i, dout_valid, dout, din_ready);
            end
            din = 4'($urandom_range(0, 9));
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        dout_ready = 1'b1;
        vectors++;
        if (dout_valid !== 1'b1 || dout !== 7'd99) begin
            miscompares++;
            $display("[TB] FAIL stall_final: got valid=%b dout=%0d expected 1/99", dout_valid, dout);
        end
        tick();
        vectors++;
        if (dout_valid !== 1'b0 || dout !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL stall_consumed: got valid=%b dout=%0d expected 0/0", dout_valid, dout);
        end
        tick();
        vectors++;
        if (dout_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_once: got valid=%b expected 0", dout_valid);
        end
    endtask

    task automatic test_err;
        dout_ready = 1'b1;
        send_main(4'hA, 4'd3);
        vectors++;
        if (dout !== 7'd103 || err !== ERR_EN) begin
            miscompares++;
            $display("[TB] FAIL err_set: got dout=%0d err=%b expected 103/%b", dout, err, ERR_EN);
        end
        tick();
        send_main(4'd0, 4'd7);
        vectors++;
        if (dout !== 7'd7 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_clear: got dout=%0d err=%b expected 7/0", dout, err);
        end
        tick();
    endtask

    task automatic test_abort;
        dout_ready = 1'b1;
        din = 4'd7;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (dout_valid !== 1'b0 || dout !== 7'd0 || din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_cleared: got valid=%b dout=%0d ready=%b expected 0/0/1", dout_valid, dout, din_ready);
        end
        send_main(4'd2, 4'd1);
        vectors++;
        if (dout_valid !== 1'b1 || dout !== 7'd21) begin
            miscompares++;
            $display("[TB] FAIL abort_next: got valid=%b dout=%0d expected 1/21", dout_valid, dout);
        end
        tick();
    endtask

    task automatic test_random;
        int digs[4];
        int stall;
        longint exp_v;
        bit exp_e;
        for (int n = 0; n < 40; n++) begin
            digs[0] = int'($urandom_range(0, 15));
            digs[1] = int'($urandom_range(0, 15));
            digs[2] = 0;
            digs[3] = 0;
            stall = int'($urandom_range(0, 3));
            exp_v = model_value(digs, 2, 7);
            exp_e = model_err(digs, 2);
            dout_ready = 1'b0;
            send_main(4'(digs[0]), 4'(digs[1]));
            for (int s = 0; s < stall; s++) tick();
            dout_ready = 1'b1;
            vectors++;
            if (dout_valid !== 1'b1 || dout !== 7'(exp_v) || err !== exp_e) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: got valid=%b dout=%0d err=%b expected 1/%0d/%b", n, dout_valid, dout, err, exp_v, exp_e);
            end
            tick();
            vectors++;
            if (dout_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL random_consume_%0d: got valid=%b expected 0", n, dout_valid);
            end
        end
    endtask

    task automatic test_wide;
        int digs[4];
        w_dout_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) digs[i] = (n == 0) ? 9 : int'($urandom_range(0, 15));
            send_wide(digs);
            vectors++;
            if (w14_dout_valid !== 1'b1 || w14_dout !== 14'(model_value(digs, 4, 14)) || w14_err !== model_err(digs, 4)) begin
                miscompares++;
                $display("[TB] FAIL wide14_%0d: got valid=%b dout=%0d err=%b expected 1/%0d/%b", n, w14_dout_valid, w14_dout, w14_err, model_value(digs, 4, 14), model_err(digs, 4));
            end
            vectors++;
            if (w7_dout_valid !== 1'b1 || w7_dout !== 7'(model_value(digs, 4, 7))) begin
                miscompares++;
                $display("[TB] FAIL wide7_%0d: got valid=%b dout=%0d expected 1/%0d", n, w7_dout_valid, w7_dout, model_value(digs, 4, 7));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_stall();
        test_err();
        test_abort();
        test_random();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
